// File: rtl/parking_gate_ctrl.sv
// Parking access FSM: checks entry/passage sensors and PIN strobes, drives the gate and the alarms.
// Latency: one cycle; an input sampled at edge N sets state and all registered outputs right after edge N.
// Backpressure: none. pin_valid is a one-cycle strobe, and any strobe the current state ignores is dropped.
module parking_gate_ctrl #(
  parameter logic [8:0]  PASSWORD       = 9'b001010111,
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_1,
  input  logic       sensor_2,
  input  logic       pin_valid,
  input  logic [8:0] psswrd_atmpt,
  output logic       open_gate,
  output logic       close_gate,
  output logic       alarm_1,
  output logic       alarm_2,
  output logic [1:0] attempts,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    WAIT_CAR    = 3'd0,
    ENTER_PIN   = 3'd1,
    AUTHORIZED  = 3'd2,
    PIN_ALARM   = 3'd3,
    BLOCK_ALARM = 3'd4
  } state_t;

  // The timer only needs to reach TIMEOUT_CYCLES-1. The timeout fires on the edge that would take it past that value.
  localparam int unsigned TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    MAX_A  = MAX_ATTEMPTS[1:0];

  state_t        cur_state;
  logic [TW-1:0] timer;
  logic [1:0]    rst_sync;
  logic          rst_n_int;
  logic          pin_ok;
  logic          pin_bad;
  logic [1:0]    att_inc;

  assign pin_ok    = pin_valid && (psswrd_atmpt == PASSWORD);
  assign pin_bad   = pin_valid && (psswrd_atmpt != PASSWORD);
  assign att_inc   = attempts + 2'd1;
  assign rst_n_int = rst_sync[1];
  assign state     = cur_state;

  // Reset asserts immediately. Its release passes through two flops so that every state flop leaves reset on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end

  // Main FSM. Each output is written in the branch that selects the next state, so the outputs always match that state.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      cur_state  <= WAIT_CAR;
      attempts   <= 2'd0;
      timer      <= '0;
      open_gate  <= 1'b0;
      close_gate <= 1'b0;
      alarm_1    <= 1'b0;
      alarm_2    <= 1'b0;
    end else begin
      close_gate <= 1'b0;
      case (cur_state)
        WAIT_CAR: begin
          if (sensor_1) begin
            cur_state <= ENTER_PIN;
            attempts  <= 2'd0;
            timer     <= '0;
          end
        end
        ENTER_PIN: begin
          if (!sensor_1) begin
            cur_state <= WAIT_CAR;
            attempts  <= 2'd0;
            timer     <= '0;
          end else if (pin_ok) begin
            cur_state <= AUTHORIZED;
            attempts  <= 2'd0;
            timer     <= '0;
            open_gate <= 1'b1;
          end else if (pin_bad) begin
            attempts <= att_inc;
            timer    <= '0;
            if (att_inc == MAX_A) begin
              cur_state <= PIN_ALARM;
              alarm_1   <= 1'b1;
            end
          end else if (timer == T_LAST) begin
            cur_state <= WAIT_CAR;
            attempts  <= 2'd0;
            timer     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        AUTHORIZED: begin
          // When both sensors are high, a second car is following through the gate. This case is checked first.
          if (sensor_1 && sensor_2) begin
            cur_state  <= BLOCK_ALARM;
            open_gate  <= 1'b0;
            close_gate <= 1'b1;
            alarm_2    <= 1'b1;
          end else if (sensor_2) begin
            cur_state  <= WAIT_CAR;
            open_gate  <= 1'b0;
            close_gate <= 1'b1;
          end
        end
        PIN_ALARM: begin
          if (pin_ok) begin
            cur_state <= AUTHORIZED;
            alarm_1   <= 1'b0;
            attempts  <= 2'd0;
            open_gate <= 1'b1;
          end
        end
        BLOCK_ALARM: begin
          if (pin_ok) begin
            cur_state <= WAIT_CAR;
            alarm_2   <= 1'b0;
          end
        end
        default: begin
          cur_state <= WAIT_CAR;
          attempts  <= 2'd0;
          timer     <= '0;
          open_gate <= 1'b0;
          alarm_1   <= 1'b0;
          alarm_2   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl. Directed steps push the expected outputs into a scoreboard queue.
// Latency: the monitor compares each entry 1 ns after the rising edge that follows the step that pushed it.
// Backpressure: none. Steps are issued once per cycle on the falling edge.
module tb_parking_gate_ctrl;

  localparam logic [8:0] PW  = 9'b001010111;
  localparam logic [8:0] BAD = 9'b001011111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sensor_1 = 1'b0;
  logic       sensor_2 = 1'b0;
  logic       pin_valid = 1'b0;
  logic [8:0] psswrd_atmpt = 9'd0;
  logic       open_gate, close_gate, alarm_1, alarm_2;
  logic [1:0] attempts;
  logic [2:0] state;
  logic [8:0] obs;

  int n_chk  = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];
  string      name_q[$];
  bit         chk_q[$];

  parking_gate_ctrl dut (
    .clk(clk), .rst(rst), .sensor_1(sensor_1), .sensor_2(sensor_2),
    .pin_valid(pin_valid), .psswrd_atmpt(psswrd_atmpt),
    .open_gate(open_gate), .close_gate(close_gate), .alarm_1(alarm_1),
    .alarm_2(alarm_2), .attempts(attempts), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {state, open_gate, close_gate, alarm_1, alarm_2, attempts};

  // Fields: state, open_gate, close_gate, alarm_1, alarm_2, attempts.
  function automatic logic [8:0] ex(input logic [2:0] st, input logic og, input logic cg,
                                    input logic a1, input logic a2, input logic [1:0] att);
    return {st, og, cg, a1, a2, att};
  endfunction

  task automatic compare(input string nm, input logic [8:0] act, input logic [8:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got st=%0d og=%b cg=%b a1=%b a2=%b att=%0d, want st=%0d og=%b cg=%b a1=%b a2=%b att=%0d",
               nm, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
               want[8:6], want[5], want[4], want[3], want[2], want[1:0]);
    end
  endtask

  // Monitor: after each rising edge, pop one expected entry and compare it with the DUT outputs.
  initial begin
    logic [8:0] e;
    string      nm;
    bit         c;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        c  = chk_q.pop_front();
        if (c) compare(nm, obs, e);
      end
    end
  end

  task automatic step(input logic s1, input logic s2, input logic pv, input logic [8:0] pin,
                      input logic [8:0] want, input string nm, input bit c);
    @(negedge clk);
    sensor_1     = s1;
    sensor_2     = s2;
    pin_valid    = pv;
    psswrd_atmpt = pin;
    exp_q.push_back(want);
    name_q.push_back(nm);
    chk_q.push_back(c);
  endtask

  // Release reset with a car waiting. No transition is allowed on the first edge after release, and ENTER_PIN must follow within a few edges.
  task automatic sync_release(input string tag);
    bit found;
    found = 1'b0;
    @(negedge clk);
    rst = 1'b1; sensor_1 = 1'b1; sensor_2 = 1'b0; pin_valid = 1'b0; psswrd_atmpt = 9'd0;
    @(posedge clk);
    #1;
    compare({tag, "_edge1_no_change"}, obs, ex(3'd0, 0, 0, 0, 0, 2'd0));
    for (int i = 0; i < 6 && !found; i++) begin
      @(posedge clk);
      #1;
      if (state == 3'd1) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s_enter_after_release: state=%0d, required 1 within 6 edges", tag, state);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in the scoreboard, required 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    compare("reset_state", obs, 9'd0);
    sync_release("por");

    // Normal entry, then the car passes the gate.
    step(1, 0, 1, PW,   ex(3'd2, 1, 0, 0, 0, 2'd0), "ne_auth", 1);
    step(0, 0, 0, 9'd0, ex(3'd2, 1, 0, 0, 0, 2'd0), "ne_hold_open", 1);
    step(0, 1, 0, 9'd0, ex(3'd0, 0, 1, 0, 0, 2'd0), "ne_pass_close", 1);
    step(0, 0, 0, 9'd0, ex(3'd0, 0, 0, 0, 0, 2'd0), "ne_close_one_cycle", 1);

    // Two wrong PINs, then the correct one.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "tw_enter", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd1), "tw_wrong1", 1);
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd1), "tw_idle", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd2), "tw_wrong2", 1);
    step(1, 0, 1, PW,   ex(3'd2, 1, 0, 0, 0, 2'd0), "tw_auth", 1);
    step(0, 1, 0, 9'd0, ex(3'd0, 0, 1, 0, 0, 2'd0), "tw_pass", 1);

    // Three wrong PINs raise alarm_1. Sensors and further wrong PINs are ignored until the correct PIN.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "pa_enter", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd1), "pa_wrong1", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd2), "pa_wrong2", 1);
    step(1, 0, 1, BAD,  ex(3'd3, 0, 0, 1, 0, 2'd3), "pa_alarm", 1);
    step(0, 1, 1, BAD,  ex(3'd3, 0, 0, 1, 0, 2'd3), "pa_saturate", 1);
    step(0, 0, 1, PW,   ex(3'd2, 1, 0, 0, 0, 2'd0), "pa_clear_auth", 1);

    // Tailgating from AUTHORIZED raises alarm_2. Only the correct PIN clears it.
    step(1, 1, 0, 9'd0, ex(3'd4, 0, 1, 0, 1, 2'd0), "tg_block", 1);
    step(0, 0, 0, 9'd0, ex(3'd4, 0, 0, 0, 1, 2'd0), "tg_hold", 1);
    step(1, 0, 1, BAD,  ex(3'd4, 0, 0, 0, 1, 2'd0), "tg_wrong_ignored", 1);
    step(0, 0, 1, PW,   ex(3'd0, 0, 0, 0, 0, 2'd0), "tg_clear", 1);

    // Car leaves in the same cycle as a correct strobe. The leave takes priority.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "ab_enter", 1);
    step(0, 0, 1, PW,   ex(3'd0, 0, 0, 0, 0, 2'd0), "ab_leave_wins", 1);

    // Plain timeout: ENTER_PIN is abandoned on the 16th idle edge after entry.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "to_enter", 1);
    for (int i = 0; i < 15; i++)
      step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "to_wait", 1);
    step(1, 0, 0, 9'd0, ex(3'd0, 0, 0, 0, 0, 2'd0), "to_fire", 1);

    // A wrong strobe restarts the timeout count.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "tr_enter", 1);
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "tr_pre", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd1), "tr_wrong", 1);
    for (int i = 0; i < 15; i++)
      step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd1), "tr_wait", 1);
    step(1, 0, 0, 9'd0, ex(3'd0, 0, 0, 0, 0, 2'd0), "tr_fire", 1);

    // Asynchronous reset during PIN_ALARM clears the outputs without waiting for a clock edge.
    step(1, 0, 0, 9'd0, ex(3'd1, 0, 0, 0, 0, 2'd0), "rm_enter", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd1), "rm_wrong1", 1);
    step(1, 0, 1, BAD,  ex(3'd1, 0, 0, 0, 0, 2'd2), "rm_wrong2", 1);
    step(1, 0, 1, BAD,  ex(3'd3, 0, 0, 1, 0, 2'd3), "rm_alarm", 1);
    drain();
    @(negedge clk);
    #2;
    rst = 1'b0; sensor_1 = 1'b0; pin_valid = 1'b0;
    #1;
    compare("async_reset_immediate", obs, 9'd0);
    repeat (2) @(negedge clk);
    compare("reset_held", obs, 9'd0);
    sync_release("mid");
    step(1, 0, 1, PW,   ex(3'd2, 1, 0, 0, 0, 2'd0), "mid_session_fresh", 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
